// File: rtl/req_chan_arbiter.sv
// Round-robin arbiter sharing one request (address) channel among four
// managers. A one-cycle grant pulse names the winner. The shared channel
// is then routed to that owner until its a_valid/a_ready handshake
// completes. A watchdog releases the channel if the owner never presents
// a_valid.
module req_chan_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   m_req_rq,
    output logic [3:0]   m_gnt_rq,
    input  logic [3:0]   m_a_valid,
    output logic [3:0]   m_a_ready,
    input  logic [15:0]  m_a_id,
    input  logic [127:0] m_a_addr,
    input  logic [23:0]  m_a_atop,
    output logic         s_a_valid,
    input  logic         s_a_ready,
    output logic [3:0]   s_a_id,
    output logic [31:0]  s_a_addr,
    output logic [5:0]   s_a_atop,
    output logic [1:0]   owner,
    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [1:0]       winner;
    logic             own_valid;
    logic [3:0]       id_arr   [4];
    logic [31:0]      addr_arr [4];
    logic [5:0]       atop_arr [4];

    // Split the flat per-manager buses into indexable slices
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            id_arr[i]   = m_a_id[4*i +: 4];
            addr_arr[i] = m_a_addr[32*i +: 32];
            atop_arr[i] = m_a_atop[6*i +: 6];
        end
    end

    // Round-robin pick: first request scanning owner+1 .. owner+4 (mod 4)
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = owner_q;
        found  = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = owner_q + 2'(k);
            if (!found && m_req_rq[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign own_valid = m_a_valid[owner_q];

    // Next-state, grant, watchdog counter and timeout pulse
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = '0;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m_req_rq != 4'b0000) begin
                    state_d = ST_GNT;
                    owner_d = winner;
                    gnt_d   = 4'b0001 << winner;
                end
            end
            ST_GNT: begin
                state_d = ST_BUSY;
                cnt_d   = '0;
            end
            ST_BUSY: begin
                if (own_valid && s_a_ready) begin
                    state_d = ST_IDLE;
                end else if (!own_valid) begin
                    if (cnt_q == CNT_TERM) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, owner, grant pulse, counter and error pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd3;
            gnt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Route the owner's channel to the slave side only while BUSY
    always_comb begin
        s_a_valid = 1'b0;
        s_a_id    = '0;
        s_a_addr  = '0;
        s_a_atop  = '0;
        m_a_ready = '0;
        if (state_q == ST_BUSY) begin
            s_a_valid          = own_valid;
            s_a_id             = id_arr[owner_q];
            s_a_addr           = addr_arr[owner_q];
            s_a_atop           = atop_arr[owner_q];
            m_a_ready[owner_q] = s_a_ready;
        end
    end

    assign m_gnt_rq    = gnt_q;
    assign owner       = owner_q;
    assign busy        = (state_q == ST_GNT) || (state_q == ST_BUSY);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_req_chan_arbiter.sv
// Directed-vector bench for req_chan_arbiter with hand-computed expectations.
module tb_req_chan_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   m_req_rq;
    logic [3:0]   m_gnt_rq;
    logic [3:0]   m_a_valid;
    logic [3:0]   m_a_ready;
    logic [15:0]  m_a_id;
    logic [127:0] m_a_addr;
    logic [23:0]  m_a_atop;
    logic         s_a_valid;
    logic         s_a_ready;
    logic [3:0]   s_a_id;
    logic [31:0]  s_a_addr;
    logic [5:0]   s_a_atop;
    logic [1:0]   owner;
    logic         busy;
    logic         err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    req_chan_arbiter #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_rq    (m_req_rq),
        .m_gnt_rq    (m_gnt_rq),
        .m_a_valid   (m_a_valid),
        .m_a_ready   (m_a_ready),
        .m_a_id      (m_a_id),
        .m_a_addr    (m_a_addr),
        .m_a_atop    (m_a_atop),
        .s_a_valid   (s_a_valid),
        .s_a_ready   (s_a_ready),
        .s_a_id      (s_a_id),
        .s_a_addr    (s_a_addr),
        .s_a_atop    (s_a_atop),
        .owner       (owner),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         cyc;
        int         last;
        logic       found;
        logic [3:0] exp_g;

        rst       = 1'b1;
        m_req_rq  = '0;
        m_a_valid = '0;
        m_a_id    = '0;
        m_a_addr  = '0;
        m_a_atop  = '0;
        s_a_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_gnt", 32'(m_gnt_rq), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h3);
        check("rst_err", 32'(err_timeout), 32'h0);
        check("rst_svalid", 32'(s_a_valid), 32'h0);

        // 1: single request from manager 0, immediate handshake
        m_req_rq        = 4'b0001;
        m_a_valid       = 4'b0001;
        m_a_addr[31:0]  = 32'h1000_0040;
        m_a_id[3:0]     = 4'h1;
        m_a_atop[5:0]   = 6'h2a;
        s_a_ready       = 1'b1;
        tick();
        check("t1_gnt", 32'(m_gnt_rq), 32'h1);
        check("t1_owner", 32'(owner), 32'h0);
        check("t1_gnt_svalid", 32'(s_a_valid), 32'h0);
        check("t1_gnt_ready", 32'(m_a_ready), 32'h0);
        m_req_rq = '0;
        tick();
        check("t1_gnt_drop", 32'(m_gnt_rq), 32'h0);
        check("t1_svalid", 32'(s_a_valid), 32'h1);
        check("t1_addr", s_a_addr, 32'h1000_0040);
        check("t1_id", 32'(s_a_id), 32'h1);
        check("t1_atop", 32'(s_a_atop), 32'h2a);
        check("t1_ready", 32'(m_a_ready), 32'h1);
        tick();
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_idle_ready", 32'(m_a_ready), 32'h0);
        m_a_valid = '0;

        // 2: all request, each owner completes at once -> 0,1,2,3,0 every 3 cycles
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        m_req_rq  = 4'b1111;
        m_a_valid = 4'b1111;
        s_a_ready = 1'b1;
        cyc  = 0;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                tick();
                cyc++;
                if (m_gnt_rq != 4'b0000) found = 1'b1;
            end
            exp_g = 4'b0001 << (g % 4);
            check("t2_order", 32'(m_gnt_rq), 32'(exp_g));
            if (g > 0) check("t2_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
        end
        m_req_rq = '0;
        tick();
        tick();
        check("t2_idle", 32'(busy), 32'h0);
        m_a_valid = '0;

        // 3: owner 2 stalled by s_a_ready for 5 cycles
        m_req_rq         = 4'b0100;
        m_a_valid        = 4'b0100;
        m_a_addr[95:64]  = 32'h2222_0080;
        m_a_id[11:8]     = 4'h7;
        s_a_ready        = 1'b0;
        tick();
        check("t3_gnt", 32'(m_gnt_rq), 32'h4);
        m_req_rq = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", 32'(s_a_valid), 32'h1);
            check("t3_stall_addr", s_a_addr, 32'h2222_0080);
            check("t3_stall_ready", 32'(m_a_ready), 32'h0);
            check("t3_stall_err", 32'(err_timeout), 32'h0);
            tick();
        end
        s_a_ready = 1'b1;
        #1;
        check("t3_last_valid", 32'(s_a_valid), 32'h1);
        check("t3_last_addr", s_a_addr, 32'h2222_0080);
        check("t3_last_ready", 32'(m_a_ready), 32'h4);
        tick();
        check("t3_end_busy", 32'(busy), 32'h0);
        check("t3_end_err", 32'(err_timeout), 32'h0);
        m_a_valid = '0;

        // 4: owner 1 never raises a_valid, watchdog at TIMEOUT_CYC=4
        m_req_rq = 4'b0010;
        tick();
        check("t4_gnt", 32'(m_gnt_rq), 32'h2);
        m_req_rq = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_wait_err", 32'(err_timeout), 32'h0);
            check("t4_wait_busy", 32'(busy), 32'h1);
        end
        tick();
        check("t4_err", 32'(err_timeout), 32'h1);
        check("t4_idle", 32'(busy), 32'h0);
        m_req_rq = 4'b0110;
        tick();
        check("t4_err_pulse", 32'(err_timeout), 32'h0);
        check("t4_next_gnt", 32'(m_gnt_rq), 32'h4);
        m_req_rq  = '0;
        m_a_valid = 4'b0100;
        s_a_ready = 1'b1;
        tick();
        tick();
        m_a_valid = '0;
        s_a_ready = 1'b0;

        // 6: non-owner valid ignored while owner 3 is BUSY
        m_req_rq          = 4'b1000;
        m_a_id[15:12]     = 4'hc;
        m_a_id[7:4]       = 4'h5;
        m_a_addr[127:96]  = 32'h3333_00c0;
        tick();
        check("t6_gnt", 32'(m_gnt_rq), 32'h8);
        m_req_rq  = '0;
        m_a_valid = 4'b1010;
        tick();
        check("t6_owner", 32'(owner), 32'h3);
        check("t6_id", 32'(s_a_id), 32'hc);
        check("t6_addr", s_a_addr, 32'h3333_00c0);
        check("t6_ready_stall", 32'(m_a_ready), 32'h0);
        s_a_ready = 1'b1;
        #1;
        check("t6_ready", 32'(m_a_ready), 32'h8);

        // 5: reset mid-transfer for owner 3, then manager 0 wins first
        rst = 1'b1;
        tick();
        check("t5_gnt", 32'(m_gnt_rq), 32'h0);
        check("t5_svalid", 32'(s_a_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_owner", 32'(owner), 32'h3);
        rst       = 1'b0;
        m_a_valid = '0;
        s_a_ready = 1'b0;
        m_req_rq  = 4'b1001;
        tick();
        check("t5_first_gnt", 32'(m_gnt_rq), 32'h1);
        m_req_rq = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
